latch_sipo_capture: RTL and testbench
=====================================

Name: latch_sipo_capture

Overview:
- Downstream consumer of the level-sensitive D-latch stage.
- Synchronises the latch's Q output into the Clock domain and shifts it serially into a WIDTH-bit word.
- Presents each completed word on a valid/ready interface through a one-word output buffer.
- Reports dropped words through a sticky overrun flag.

Parameters:
WIDTH, 8, bits per assembled word (legal range 2..32)
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (legal range 2..4)
MSB_FIRST, 1, 1 = first received bit lands in Data_out[WIDTH-1]; 0 = first bit lands in Data_out[0]

Ports:
Clock  input  1  single rising-edge clock for all state
Reset_n  input  1  asynchronous, active-low reset
input1  input  1  serial bit from the latch Q output; asynchronous to Clock
Enable  input  1  shift strobe; qualifies the synchronised bit in the same cycle
Ready  input  1  downstream accepts Data_out when Valid is high
Clear_ovr  input  1  synchronous clear of Overrun
Data_out  output  WIDTH  assembled word
Valid  output  1  Data_out holds an unconsumed word
Overrun  output  1  sticky flag: a completed word was dropped
Bit_count  output  $clog2(WIDTH)  bits shifted into the current partial word

Behaviour:
- Reset (Reset_n=0) acts immediately, without waiting for Clock:
  - Clears the synchroniser, shift register, Bit_count, Data_out, Valid and Overrun to 0.
  - Forces the buffer state to BUF_EMPTY.
  - Discards any partial or buffered word.
  - Release is synchronous to the next rising Clock edge.
- Synchroniser: input1 passes through SYNC_STAGES flops.
  - sbit = last stage.
  - Latency from input1 to a shiftable sbit = SYNC_STAGES rising edges.
- Shift, on each rising edge with Enable=1:
  - sbit enters the shift register.
  - MSB_FIRST=1: shift left, insert at bit 0. MSB_FIRST=0: shift right, insert at bit WIDTH-1.
  - Bit_count increments.
- Enable=0: shift register and Bit_count hold.
- Word completion: a shift while Bit_count == WIDTH-1.
  - Bit_count wraps to 0 on that same edge.
  - The completed word is the shift register contents including sbit.
- Output buffer FSM, states BUF_EMPTY / BUF_FULL:
  - BUF_EMPTY + completion -> load Data_out, go to BUF_FULL; Valid=1 from the next cycle.
  - BUF_FULL + Ready=1, no completion -> go to BUF_EMPTY; Valid=0 next cycle; Data_out holds its last value.
  - BUF_FULL + Ready=1 + completion in the same cycle -> load the new word, stay BUF_FULL; Valid remains 1 with no gap.
  - BUF_FULL + Ready=0 + completion -> new word dropped, Data_out unchanged, Overrun=1 next cycle.
- Valid = (state == BUF_FULL). Registered, with no combinational path from Ready.
- Overrun:
  - Stays set until Clear_ovr=1 or reset.
  - If a new overrun and Clear_ovr occur in the same cycle, set wins.
- Handshake rule: Data_out must not change while Valid=1 && Ready=0.
- Enable toggling has no effect on the buffer FSM apart from completions.

Decomposition:
- Package latch_capture_pkg holds:
  - enum buf_state_t {BUF_EMPTY, BUF_FULL};
  - a count-width constant function cnt_w(WIDTH) = $clog2(WIDTH).
- Sub-module bit_synchronizer:
  - Parameter SYNC_STAGES.
  - Ports Clock, Reset_n, d_in, d_sync.
  - Async-clears to 0; reusable for other latch-domain inputs.
- Top level holds the shift register, counter and buffer FSM.

Test Plan:
- Reset: assert Reset_n=0 mid-clock with Valid=1 and Overrun=1 -> all outputs 0 immediately, before any Clock edge; Bit_count=0.
- MSB-first word (WIDTH=8): bits 1,1,0,0,1,0,0,0 with Enable=1 and Ready=1 -> Valid pulses for 1 cycle with Data_out=8'hC8, first asserted 1 cycle after the 8th shift; Overrun=0.
- LSB-first (MSB_FIRST=0): same bit stream -> Data_out=8'h13.
- Back-pressure: Ready=0, send 8'hC8 then 8'hA5 -> Data_out stays 8'hC8, Valid=1, Overrun=1 after the 2nd word. Then Ready=1 for 1 cycle -> Valid=0. Then Clear_ovr=1 -> Overrun=0.
- Gapped Enable: interleave Enable=0 cycles between bits of 8'hA5 -> Bit_count holds during gaps; Data_out=8'hA5.
- Reset mid-word plus simultaneous accept/complete:
  - Reset after 5 bits, then send 8'h3C -> Bit_count restarts at 0; Data_out=8'h3C.
  - With Valid=1, Ready=1 on the completion cycle of 8'h81 -> Valid stays 1 and Data_out becomes 8'h81 the next cycle, with no Valid gap.

Source files
------------

// File: rtl/latch_sipo_capture_pkg.sv
// ============================================================================
// Module   : latch_capture_pkg
// Purpose  : Shared types and helpers for the latch SIPO capture block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package latch_capture_pkg;

  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Width of a counter that indexes bit positions inside a word.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/latch_sipo_capture_if.sv
// ============================================================================
// Module   : latch_sipo_capture_if
// Purpose  : Valid/ready word interface from the capture block to its consumer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface latch_sipo_capture_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] Data_out;
  logic             Valid;
  logic             Ready;

  modport master (output Data_out, output Valid, input Ready);
  modport slave  (input Data_out, input Valid, output Ready);

endinterface

`default_nettype wire

// File: rtl/latch_sipo_capture_bit_synchronizer.sv
// ============================================================================
// Module   : bit_synchronizer
// Purpose  : Multi-flop synchroniser for a single asynchronous bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic Clock,
  input  wire logic Reset_n,
  input  wire logic d_in,
  output logic      d_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign d_sync = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/latch_sipo_capture.sv
// ============================================================================
// Module   : latch_sipo_capture
// Purpose  : Synchronise a latch output, assemble WIDTH-bit words, and hand
//            them off through a one-word valid/ready buffer with overrun flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module latch_sipo_capture
  import latch_capture_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  wire logic                      Clock,
  input  wire logic                      Reset_n,
  input  wire logic                      input1,
  input  wire logic                      Enable,
  input  wire logic                      Clear_ovr,
  latch_sipo_capture_if.master           out_if,
  output logic                           Overrun,
  output logic [cnt_w(WIDTH)-1:0]        Bit_count
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic             sbit;
  // Only WIDTH-1 earlier bits need storing; the final bit joins straight
  // from sbit on the completing edge.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    count_q;
  logic             complete;
  logic             load;
  logic             ovr_set;
  logic             ovr_q;
  buf_state_t       state_q;
  buf_state_t       state_d;

  bit_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .d_in    (input1),
    .d_sync  (sbit)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign next_word = {shreg, sbit};
    end else begin : g_lsb_first
      assign next_word = {sbit, shreg};
    end
  endgenerate

  assign complete = Enable && (count_q == LAST_BIT);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      shreg   <= '0;
      count_q <= '0;
    end else if (Enable) begin
      shreg   <= MSB_FIRST ? next_word[WIDTH-2:0] : next_word[WIDTH-1:1];
      count_q <= complete ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (complete) begin
          // Accept and refill on the same edge keeps Valid high with no gap.
          if (out_if.Ready) begin
            load = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end else if (out_if.Ready) begin
          state_d = BUF_EMPTY;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (load) begin
        data_q <= next_word;
      end
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (Clear_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign out_if.Data_out = data_q;
  assign out_if.Valid    = (state_q == BUF_FULL);
  assign Overrun         = ovr_q;
  assign Bit_count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_latch_sipo_capture.sv
// ============================================================================
// Module   : tb_latch_sipo_capture
// Purpose  : Directed self-checking bench for MSB-first and LSB-first capture.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_latch_sipo_capture;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       input1;
  logic       Enable;
  logic       Clear_ovr;
  logic       ready;
  logic       ovr_m, ovr_l;
  logic [2:0] cnt_m, cnt_l;

  int total = 0;
  int bad   = 0;

  latch_sipo_capture_if #(.WIDTH(WIDTH)) if_m ();
  latch_sipo_capture_if #(.WIDTH(WIDTH)) if_l ();

  assign if_m.Ready = ready;
  assign if_l.Ready = ready;

  always #5 Clock = ~Clock;

  latch_sipo_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) dut_m (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .input1    (input1),
    .Enable    (Enable),
    .Clear_ovr (Clear_ovr),
    .out_if    (if_m),
    .Overrun   (ovr_m),
    .Bit_count (cnt_m)
  );

  latch_sipo_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b0)) dut_l (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .input1    (input1),
    .Enable    (Enable),
    .Clear_ovr (Clear_ovr),
    .out_if    (if_l),
    .Overrun   (ovr_l),
    .Bit_count (cnt_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Hold the bit long enough to cross the synchroniser, then strobe once.
  task automatic send_bit(input logic b);
    input1 = b;
    Enable = 1'b0;
    repeat (SYNC) tick();
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    Reset_n   = 1'b0;
    input1    = 1'b0;
    Enable    = 1'b0;
    Clear_ovr = 1'b0;
    ready     = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_valid", 32'(if_m.Valid), 32'd0);
    check("rst_data",  32'(if_m.Data_out), 32'd0);
    check("rst_ovr",   32'(ovr_m), 32'd0);
    check("rst_cnt",   32'(cnt_m), 32'd0);
    Reset_n = 1'b1;
    tick();

    // MSB-first and LSB-first views of the same stream
    ready = 1'b1;
    send_word(8'hC8);
    check("msb_valid", 32'(if_m.Valid), 32'd1);
    check("msb_data",  32'(if_m.Data_out), 32'hC8);
    check("lsb_data",  32'(if_l.Data_out), 32'h13);
    check("msb_ovr",   32'(ovr_m), 32'd0);
    check("msb_cnt",   32'(cnt_m), 32'd0);
    tick();
    check("msb_pulse", 32'(if_m.Valid), 32'd0);
    check("msb_hold",  32'(if_m.Data_out), 32'hC8);

    // Back-pressure and overrun
    ready = 1'b0;
    send_word(8'hC8);
    check("bp_valid1", 32'(if_m.Valid), 32'd1);
    check("bp_ovr1",   32'(ovr_m), 32'd0);
    send_word(8'hA5);
    check("bp_data",   32'(if_m.Data_out), 32'hC8);
    check("bp_valid2", 32'(if_m.Valid), 32'd1);
    check("bp_ovr2",   32'(ovr_m), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("bp_drain",  32'(if_m.Valid), 32'd0);
    check("bp_ovr_st", 32'(ovr_m), 32'd1);
    Clear_ovr = 1'b1;
    tick();
    Clear_ovr = 1'b0;
    check("bp_clr",    32'(ovr_m), 32'd0);

    // Gapped enable: count holds through idle cycles
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'(8'hA5 >> i));
      if (i == 5) begin
        check("gap_cnt0", 32'(cnt_m), 32'd3);
        repeat (3) tick();
        check("gap_cnt1", 32'(cnt_m), 32'd3);
      end
    end
    check("gap_data",  32'(if_m.Data_out), 32'hA5);
    check("gap_valid", 32'(if_m.Valid), 32'd1);

    // Overrun again, then a partial word, then asynchronous reset mid-clock
    send_word(8'h5A);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("pre_cnt",   32'(cnt_m), 32'd5);
    check("pre_valid", 32'(if_m.Valid), 32'd1);
    check("pre_ovr",   32'(ovr_m), 32'd1);
    #4;
    Reset_n = 1'b0;
    #1;
    check("ar_valid",  32'(if_m.Valid), 32'd0);
    check("ar_ovr",    32'(ovr_m), 32'd0);
    check("ar_data",   32'(if_m.Data_out), 32'd0);
    check("ar_cnt",    32'(cnt_m), 32'd0);
    #2;
    Reset_n = 1'b1;
    tick();
    check("rel_cnt",   32'(cnt_m), 32'd0);
    send_word(8'h3C);
    check("rs_data",   32'(if_m.Data_out), 32'h3C);
    check("rs_valid",  32'(if_m.Valid), 32'd1);

    // Accept and complete on the same edge
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h81 >> i));
    input1 = 1'b1;
    repeat (SYNC) tick();
    check("sim_prev",  32'(if_m.Data_out), 32'h3C);
    check("sim_pv",    32'(if_m.Valid), 32'd1);
    Enable = 1'b1;
    ready  = 1'b1;
    tick();
    Enable = 1'b0;
    ready  = 1'b0;
    check("sim_valid", 32'(if_m.Valid), 32'd1);
    check("sim_data",  32'(if_m.Data_out), 32'h81);
    check("sim_ovr",   32'(ovr_m), 32'd0);
    ready = 1'b1;
    tick();
    check("sim_drain", 32'(if_m.Valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
